// File: rtl/ieee754_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ieee754_pkg
// Description : Shared definitions for the pipelined IEEE-754 adder:
//               width-derived helpers, canonical quiet NaN, exception flag
//               bit indices and operand class encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ieee754_pkg;

    // Bit positions inside the 3-bit flags word {invalid, overflow, inexact}
    localparam int FLG_INV = 2;
    localparam int FLG_OVF = 1;
    localparam int FLG_INX = 0;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_e;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int fp_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int fp_exp_ones(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    // Positive quiet NaN: all-ones exponent, only the fraction MSB set.
    // Returned right-aligned in 64 bits; callers truncate to their width.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = 64'(fp_exp_ones(exp_w)) << man_w;
        v = v | (64'd1 << (man_w - 1));
        return v;
    endfunction

    // Zero and subnormal exponents both classify as ZERO (flush-to-zero).
    function automatic fp_class_e fp_classify(input logic exp_zero,
                                              input logic exp_ones,
                                              input logic frac_zero);
        if (exp_zero)       return ZERO;
        else if (!exp_ones) return NORM;
        else if (frac_zero) return INF;
        else                return NAN;
    endfunction

endpackage : ieee754_pkg
`default_nettype wire

// File: rtl/ieee754_lzc.sv
`default_nettype none
// ============================================================================
// Module      : ieee754_lzc
// Description : Leading-zero counter. Returns the number of zero bits above
//               the most significant one; an all-zero input returns WIDTH.
// Ports       : i_value [WIDTH-1:0]         - word to scan
//               o_count [$clog2(WIDTH+1)-1:0] - leading zero count
// Revision    : 1.0 - initial release
// ============================================================================
module ieee754_lzc #(
    parameter int WIDTH = 27
) (
    input  logic [WIDTH-1:0]           i_value,
    output logic [$clog2(WIDTH+1)-1:0] o_count
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             w_found;
    logic [CNT_W-1:0] w_count;

    always_comb begin
        w_found = 1'b0;
        w_count = CNT_W'(WIDTH);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!w_found && i_value[i]) begin
                w_found = 1'b1;
                w_count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

    assign o_count = w_count;

endmodule : ieee754_lzc
`default_nettype wire

// File: rtl/ieee754_add_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ieee754_add_pipe
// Description : Four-stage pipelined IEEE-754 adder/subtractor with
//               valid/ready handshake and global stall. Subnormals are
//               flushed to zero on input and output.
//               Stages: unpack/classify/swap, align, add, normalise/round.
// Options     : IEEE754_ADD_ROUND_EN - round-to-nearest-even when defined,
//               truncation (toward zero) otherwise.
// Ports       : clk, rst_n (async, active low)
//               in_valid/in_ready, op_sub, a, b   - operand beat
//               out_valid/out_ready, z, flags     - result beat
//               flags = {invalid, overflow, inexact}
// Revision    : 1.0 - initial release
// ============================================================================
module ieee754_add_pipe
    import ieee754_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   op_sub,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   z,
    output logic [2:0]             flags
);

    localparam int W  = fp_width(EXP_W, MAN_W);
    localparam int MX = MAN_W + 4;          // hidden + fraction + guard/round/sticky
    localparam int AW = MAN_W + 3;          // aligned bits kept before the sticky fold
    localparam int CW = $clog2(MX + 1);
    localparam int XW = EXP_W + CW + 2;     // signed exponent with under/overflow room

    localparam logic [W-1:0]         c_QNAN       = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic [EXP_W-1:0]     c_EXP_ONES   = '1;
    localparam logic [EXP_W-1:0]     c_AW_E       = EXP_W'(AW);
    localparam logic signed [XW-1:0] c_ONE_X      = XW'(1);
    localparam logic signed [XW-1:0] c_EXP_ONES_X = XW'(fp_exp_ones(EXP_W));

    logic w_adv;

    // Stage registers
    logic             r_s1_valid, r_s1_sign, r_s1_eff_sub, r_s1_ovr;
    logic [EXP_W-1:0] r_s1_exp, r_s1_d;
    logic [MAN_W:0]   r_s1_big_man, r_s1_small_man;
    logic [W-1:0]     r_s1_ovr_z;
    logic [2:0]       r_s1_ovr_f;

    logic             r_s2_valid, r_s2_sign, r_s2_eff_sub, r_s2_ovr;
    logic [EXP_W-1:0] r_s2_exp;
    logic [MX-1:0]    r_s2_big_man, r_s2_small_man;
    logic [W-1:0]     r_s2_ovr_z;
    logic [2:0]       r_s2_ovr_f;

    logic             r_s3_valid, r_s3_sign, r_s3_ovr;
    logic [EXP_W-1:0] r_s3_exp;
    logic [MX:0]      r_s3_sum;
    logic [W-1:0]     r_s3_ovr_z;
    logic [2:0]       r_s3_ovr_f;

    logic             r_out_valid;
    logic [W-1:0]     r_z;
    logic [2:0]       r_flags;

    // Every stage moves together; nothing moves while the result is stuck.
    assign w_adv    = out_ready || !r_out_valid;
    assign in_ready = w_adv;

    // ------------------------------------------------------------------
    // S1: unpack, classify, special-case override, magnitude swap
    // ------------------------------------------------------------------
    logic                   w_sa, w_sb, w_a_big, w_eff_sub;
    logic [EXP_W-1:0]       w_ea, w_eb;
    logic [MAN_W-1:0]       w_fa, w_fb;
    fp_class_e              w_ca, w_cb;
    logic [EXP_W+MAN_W-1:0] w_mag_a, w_mag_b;
    logic [MAN_W:0]         w_man_a, w_man_b;
    logic [EXP_W-1:0]       w_big_exp, w_small_exp;
    logic                   w_ovr;
    logic [W-1:0]           w_ovr_z;
    logic [2:0]             w_ovr_f;

    assign w_sa = a[W-1];
    assign w_ea = a[W-2:MAN_W];
    assign w_fa = a[MAN_W-1:0];
    assign w_sb = b[W-1] ^ op_sub;
    assign w_eb = b[W-2:MAN_W];
    assign w_fb = b[MAN_W-1:0];

    assign w_ca = fp_classify(w_ea == '0, w_ea == c_EXP_ONES, w_fa == '0);
    assign w_cb = fp_classify(w_eb == '0, w_eb == c_EXP_ONES, w_fb == '0);

    // Flushed magnitudes: {exp, frac} ordering equals numeric ordering.
    assign w_mag_a = (w_ca == ZERO) ? '0 : {w_ea, w_fa};
    assign w_mag_b = (w_cb == ZERO) ? '0 : {w_eb, w_fb};
    assign w_man_a = {w_ca != ZERO, w_mag_a[MAN_W-1:0]};
    assign w_man_b = {w_cb != ZERO, w_mag_b[MAN_W-1:0]};

    assign w_a_big     = (w_mag_a >= w_mag_b);
    assign w_eff_sub   = w_sa ^ w_sb;
    assign w_big_exp   = w_a_big ? w_mag_a[EXP_W+MAN_W-1:MAN_W] : w_mag_b[EXP_W+MAN_W-1:MAN_W];
    assign w_small_exp = w_a_big ? w_mag_b[EXP_W+MAN_W-1:MAN_W] : w_mag_a[EXP_W+MAN_W-1:MAN_W];

    always_comb begin
        w_ovr   = 1'b1;
        w_ovr_z = '0;
        w_ovr_f = '0;
        if (w_ca == NAN || w_cb == NAN || (w_ca == INF && w_cb == INF && w_eff_sub)) begin
            w_ovr_z          = c_QNAN;
            w_ovr_f[FLG_INV] = 1'b1;
        end else if (w_ca == INF) begin
            w_ovr_z = {w_sa, c_EXP_ONES, {MAN_W{1'b0}}};
        end else if (w_cb == INF) begin
            w_ovr_z = {w_sb, c_EXP_ONES, {MAN_W{1'b0}}};
        end else if (w_ca == ZERO && w_cb == ZERO) begin
            // Only -0 + -0 keeps a negative sign.
            w_ovr_z = {w_sa & w_sb, {(W-1){1'b0}}};
        end else if (w_ca == ZERO) begin
            w_ovr_z = {w_sb, w_mag_b};
        end else if (w_cb == ZERO) begin
            w_ovr_z = {w_sa, w_mag_a};
        end else if (w_eff_sub && (w_mag_a == w_mag_b)) begin
            w_ovr_z = '0;
        end else begin
            w_ovr = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // S2: align the smaller mantissa, folding shifted-out bits into sticky
    // ------------------------------------------------------------------
    logic [2*AW-1:0] w_wide;
    logic [MX-1:0]   w_small_al;

    assign w_wide     = {r_s1_small_man, 2'b00, {AW{1'b0}}} >> r_s1_d;
    assign w_small_al = (r_s1_d >= c_AW_E) ? {{AW{1'b0}}, |r_s1_small_man}
                                           : {w_wide[2*AW-1:AW], |w_wide[AW-1:0]};

    // ------------------------------------------------------------------
    // S3: add or subtract magnitudes (big >= small, so never negative)
    // ------------------------------------------------------------------
    logic [MX:0] w_sum;

    assign w_sum = r_s2_eff_sub ? ({1'b0, r_s2_big_man} - {1'b0, r_s2_small_man})
                                : ({1'b0, r_s2_big_man} + {1'b0, r_s2_small_man});

    // ------------------------------------------------------------------
    // S4: normalise, round, range-check, pack
    // ------------------------------------------------------------------
    logic [CW-1:0]         w_lzc;
    logic [MX-1:0]         w_shl, w_norm;
    logic signed [XW-1:0]  w_exp_x, w_lzc_x, w_exp_n, w_exp_r;
    logic                  w_rnd_up, w_grs_nz;
    logic [MAN_W+1:0]      w_mant_r;
    logic [MAN_W-1:0]      w_frac;
    logic [W-1:0]          w_z4;
    logic [2:0]            w_f4;

    ieee754_lzc #(
        .WIDTH (MX)
    ) u_lzc (
        .i_value (r_s3_sum[MX-1:0]),
        .o_count (w_lzc)
    );

    assign w_shl   = r_s3_sum[MX-1:0] << w_lzc;
    assign w_exp_x = $signed({{(XW-EXP_W){1'b0}}, r_s3_exp});
    assign w_lzc_x = $signed({{(XW-CW){1'b0}}, w_lzc});

    always_comb begin
        if (r_s3_sum[MX]) begin
            // Carry out: drop the LSB into sticky.
            w_norm  = {r_s3_sum[MX:2], r_s3_sum[1] | r_s3_sum[0]};
            w_exp_n = w_exp_x + c_ONE_X;
        end else begin
            w_norm  = w_shl;
            w_exp_n = w_exp_x - w_lzc_x;
        end
    end

`ifdef IEEE754_ADD_ROUND_EN
    // Nearest-even: round up above half, or at exactly half when LSB is odd.
    assign w_rnd_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
`else
    assign w_rnd_up = 1'b0;
`endif

    assign w_grs_nz = |w_norm[2:0];
    assign w_mant_r = {1'b0, w_norm[MX-1:3]} + {{(MAN_W+1){1'b0}}, w_rnd_up};
    // A rounding carry leaves 10..0, so renormalising is a one-bit shift.
    assign w_exp_r  = w_mant_r[MAN_W+1] ? (w_exp_n + c_ONE_X) : w_exp_n;
    assign w_frac   = w_mant_r[MAN_W+1] ? w_mant_r[MAN_W:1] : w_mant_r[MAN_W-1:0];

    always_comb begin
        w_z4 = '0;
        w_f4 = '0;
        if (r_s3_ovr) begin
            w_z4 = r_s3_ovr_z;
            w_f4 = r_s3_ovr_f;
        end else if (r_s3_sum == '0) begin
            w_z4 = '0;
        end else if (w_exp_r >= c_EXP_ONES_X) begin
            w_z4          = {r_s3_sign, c_EXP_ONES, {MAN_W{1'b0}}};
            w_f4[FLG_OVF] = 1'b1;
            w_f4[FLG_INX] = 1'b1;
        end else if (w_exp_r[XW-1] || w_exp_r == '0) begin
            w_z4          = {r_s3_sign, {(W-1){1'b0}}};
            w_f4[FLG_INX] = 1'b1;
        end else begin
            w_z4          = {r_s3_sign, w_exp_r[EXP_W-1:0], w_frac};
            w_f4[FLG_INX] = w_grs_nz;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid     <= 1'b0;
            r_s1_sign      <= 1'b0;
            r_s1_eff_sub   <= 1'b0;
            r_s1_ovr       <= 1'b0;
            r_s1_exp       <= '0;
            r_s1_d         <= '0;
            r_s1_big_man   <= '0;
            r_s1_small_man <= '0;
            r_s1_ovr_z     <= '0;
            r_s1_ovr_f     <= '0;
            r_s2_valid     <= 1'b0;
            r_s2_sign      <= 1'b0;
            r_s2_eff_sub   <= 1'b0;
            r_s2_ovr       <= 1'b0;
            r_s2_exp       <= '0;
            r_s2_big_man   <= '0;
            r_s2_small_man <= '0;
            r_s2_ovr_z     <= '0;
            r_s2_ovr_f     <= '0;
            r_s3_valid     <= 1'b0;
            r_s3_sign      <= 1'b0;
            r_s3_ovr       <= 1'b0;
            r_s3_exp       <= '0;
            r_s3_sum       <= '0;
            r_s3_ovr_z     <= '0;
            r_s3_ovr_f     <= '0;
            r_out_valid    <= 1'b0;
            r_z            <= '0;
            r_flags        <= '0;
        end else if (w_adv) begin
            r_s1_valid     <= in_valid;
            r_s1_sign      <= w_a_big ? w_sa : w_sb;
            r_s1_eff_sub   <= w_eff_sub;
            r_s1_ovr       <= w_ovr;
            r_s1_exp       <= w_big_exp;
            r_s1_d         <= w_big_exp - w_small_exp;
            r_s1_big_man   <= w_a_big ? w_man_a : w_man_b;
            r_s1_small_man <= w_a_big ? w_man_b : w_man_a;
            r_s1_ovr_z     <= w_ovr_z;
            r_s1_ovr_f     <= w_ovr_f;

            r_s2_valid     <= r_s1_valid;
            r_s2_sign      <= r_s1_sign;
            r_s2_eff_sub   <= r_s1_eff_sub;
            r_s2_ovr       <= r_s1_ovr;
            r_s2_exp       <= r_s1_exp;
            r_s2_big_man   <= {r_s1_big_man, 3'b000};
            r_s2_small_man <= w_small_al;
            r_s2_ovr_z     <= r_s1_ovr_z;
            r_s2_ovr_f     <= r_s1_ovr_f;

            r_s3_valid     <= r_s2_valid;
            r_s3_sign      <= r_s2_sign;
            r_s3_ovr       <= r_s2_ovr;
            r_s3_exp       <= r_s2_exp;
            r_s3_sum       <= w_sum;
            r_s3_ovr_z     <= r_s2_ovr_z;
            r_s3_ovr_f     <= r_s2_ovr_f;

            r_out_valid    <= r_s3_valid;
            r_z            <= w_z4;
            r_flags        <= w_f4;
        end
    end

    assign out_valid = r_out_valid;
    assign z         = r_z;
    assign flags     = r_flags;

endmodule : ieee754_add_pipe
`default_nettype wire

// File: tb/tb_ieee754_add_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ieee754_add_pipe
// Description : Self-checking bench for ieee754_add_pipe (single precision).
//               Directed operand vectors with hand-computed results, a
//               back-pressured stream and a mid-flight reset.
//               Expected rounding results follow IEEE754_ADD_ROUND_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ieee754_add_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        op_sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z;
    logic [2:0]  flags;

    int n_chk;
    int n_err;

    ieee754_add_pipe #(
        .EXP_W (8),
        .MAN_W (23)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .flags     (flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One isolated operation: drive a beat, wait for the result, check it.
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic sub, input logic [31:0] ez, input logic [2:0] ef);
        int lat;
        a         = av;
        b         = bv;
        op_sub    = sub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_val({tag, " latency"}, 64'(lat), 64'd4);
        check_val({tag, " z"}, 64'(z), 64'(ez));
        check_val({tag, " flags"}, 64'(flags), 64'(ef));
        @(negedge clk);
    endtask

    logic [31:0] s_a   [8];
    logic [31:0] s_exp [8];

    initial begin
        int          sent, recv, cyc, extra, seen;
        logic        prev_stall;
        logic [31:0] prev_z;
        logic [3:0]  rdy_pat;

        n_chk     = 0;
        n_err     = 0;
        in_valid  = 1'b0;
        op_sub    = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #1;
        check_val("reset out_valid", 64'(out_valid), 64'd0);
        check_val("reset z", 64'(z), 64'd0);
        check_val("reset flags", 64'(flags), 64'd0);
        check_val("reset in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed operations
        run_op("add 35.75+20.5", 32'h420F0000, 32'h41A40000, 1'b0, 32'h42610000, 3'b000);
        run_op("sub 35.75-20.5", 32'h420F0000, 32'h41A40000, 1'b1, 32'h41740000, 3'b000);
`ifdef IEEE754_ADD_ROUND_EN
        run_op("round 1+1.5ulp/2", 32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b001);
`else
        run_op("round 1+1.5ulp/2", 32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800000, 3'b001);
`endif
        run_op("tie to even", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
        run_op("inf-inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100);
        run_op("inf sub inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100);
        run_op("nan input", 32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100);
        run_op("single inf", 32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 3'b000);
        run_op("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011);
        run_op("x-x", 32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 3'b000);
        run_op("subnormal in", 32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000);
        run_op("underflow", 32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 3'b001);

        // Back-to-back stream: k + 1.0 = k+1, out_ready cycling 1-0-0-1
        s_a   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                  32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        s_exp = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                  32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};
        rdy_pat    = 4'b1001;
        sent       = 0;
        recv       = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_z     = '0;
        op_sub     = 1'b0;
        b          = 32'h3F800000;
        while (recv < 8 && cyc < 200) begin
            out_ready = rdy_pat[cyc % 4];
            in_valid  = (sent < 8);
            a         = (sent < 8) ? s_a[sent] : 32'h0;
            #1;
            if (prev_stall) begin
                check_val("stall hold valid", 64'(out_valid), 64'd1);
                check_val("stall hold z", 64'(z), 64'(prev_z));
            end
            if (out_valid && out_ready) begin
                check_val($sformatf("stream z[%0d]", recv), 64'(z), 64'(s_exp[recv]));
                check_val($sformatf("stream flags[%0d]", recv), 64'(flags), 64'd0);
                recv++;
            end
            if (in_valid && in_ready) sent++;
            prev_stall = out_valid && !out_ready;
            prev_z     = z;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check_val("stream count", 64'(recv), 64'd8);
        out_ready = 1'b1;
        extra     = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (out_valid) extra++;
            @(negedge clk);
        end
        check_val("stream no extra", 64'(extra), 64'd0);

        // Reset with three beats in flight
        a         = 32'h3F800000;
        b         = 32'h3F800000;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check_val("pre-reset out_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check_val("async reset out_valid", 64'(out_valid), 64'd0);
        check_val("async reset z", 64'(z), 64'd0);
        check_val("async reset in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        seen      = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (out_valid) seen++;
            @(negedge clk);
        end
        check_val("no stale after reset", 64'(seen), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_ieee754_add_pipe
`default_nettype wire

// File: doc/ieee754_add_pipe.md
# ieee754_add_pipe

Parametrised, pipelined IEEE-754 adder/subtractor. It is the successor to the single-precision combinational `IEEE754` adder. Exponent and mantissa widths are generic, and it takes a per-operation add/sub select. It has a valid/ready stream interface with full back-pressure, handles the special cases (zero, infinity, NaN, overflow) and reports exception flags. It sits between an operand-issue stage and a result FIFO in the FP datapath.

## Interface
- `EXP_W`, 8: exponent field width; bias = 2^(EXP_W-1)-1.
- `MAN_W`, 23: stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: block accepts a beat when `in_valid && in_ready`.
- `op_sub` in 1: 0 = A+B, 1 = A−B; sampled with operands.
- `a`, `b` in W: operands, IEEE-754 packed.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts when `out_valid && out_ready`.
- `z` out W: result.
- `flags` out 3: {invalid, overflow, inexact}, aligned with `z`.

## Operation
- Four stages, each with a valid bit. Stalls are global: `adv = out_ready || !out_valid`, `in_ready = adv`. On `!adv` every stage register holds.
- S1, unpack: split the fields and insert the hidden bit. Zero or subnormal exponents are flushed to ±0; subnormal outputs are flushed too. B's sign is inverted when `op_sub`. Classify zero/inf/NaN, pick the larger magnitude by comparing {exp, man}, swap so that big = larger, and compute d = exp_big − exp_small.
- S2, align: right-shift the small mantissa by d, extended with guard, round and sticky bits. For d ≥ MAN_W+3 the shifted mantissa is all zero and sticky = OR of the small mantissa.
- S3, add: same signs give a MAN_W+4-bit add with carry; different signs give big − small (never negative after the swap). Result sign = big sign.
- S4, normalise/round/pack:
  - Carry out: shift right 1 (OR the dropped bit into sticky), exp+1.
  - Otherwise: leading-zero count, left shift, exp−lzc.
  - Exact zero difference gives +0.
  - exp ≥ 2^EXP_W−1 (including after rounding carry) gives ±inf, overflow=1, inexact=1.
  - exp ≤ 0 gives ±0, inexact=1.
- Special cases, resolved in S1 and carried as an override:
  - Any NaN input, or inf + (−inf) after `op_sub` inversion, gives canonical qNaN (0, all-ones exp, MSB of man = 1), invalid=1.
  - A single inf gives that inf.
  - x + (−x) gives +0.
  - Zero + y gives y (flushed).
- `inexact` = guard|round|sticky nonzero before rounding, or an overflow/underflow flush.

## Timing
- Latency 4 cycles from input handshake to `out_valid`, with no stall. Throughput 1 per cycle.
- Reset values: all stage valids 0, `out_valid` 0, `z` 0, `flags` 0. `in_ready` is 1 during and after reset, since it is derived from `out_valid` = 0.
- Reset mid-operation discards all in-flight beats with no output.
- `out_valid && !out_ready` holds `z`/`flags` stable until accepted.
- Simultaneous input accept and output accept in the same cycle with a full pipe is legal and loses no data.
- Stage bubbles advance and collapse only under `adv`. There is no partial-stall compaction.

## Configuration
- `IEEE754_ADD_ROUND_EN` defined: S4 applies round-to-nearest-even on guard/round/sticky. A mantissa carry from rounding renormalises (exp+1, may overflow to inf).
- Not defined: truncation (round toward zero). Guard, round and sticky are still computed for `inexact`.

## Structure
- Package `ieee754_pkg`:
  - Width-derived localparam helpers: bias, W, exp all-ones.
  - Canonical qNaN function.
  - Flag bit indices: `FLG_INV`=2, `FLG_OVF`=1, `FLG_INX`=0.
  - Class enum typedef {ZERO, NORM, INF, NAN}.
- Sub-module `ieee754_lzc`: parametrised leading-zero counter on the MAN_W+4-bit sum, used in S4.

## Test plan
- 0x420F0000 + 0x41A40000, op_sub=0 → after 4 cycles z=0x42610000, flags=000. With op_sub=1 → z=0x41740000.
- 0x3F800000 + 0x33C00000 → macro defined: z=0x3F800001, inexact=1. Undefined: z=0x3F800000, inexact=1.
- 0x7F800000 + 0xFF800000 → z=0x7FC00000, invalid=1. 0x7F7FFFFF + 0x7F7FFFFF → z=0x7F800000, overflow=1, inexact=1.
- 0x40400000 − 0x40400000 → z=0x00000000, flags=000. Subnormal 0x00000001 + 0x3F800000 → z=0x3F800000.
- Stream 8 back-to-back beats with out_ready toggling in a 1-0-0-1 pattern → all 8 results in order, none dropped or duplicated, `z` stable while stalled.
- Assert rst_n low with 3 beats in flight → out_valid=0 immediately. After release, no stale result appears.
